// File: rtl/pc_npc_fetch_unit.sv
// rtl/pc_npc_fetch_unit.sv - PC/nPC fetch sequencer with delay slot, stall hold and deferred redirect
module pc_npc_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] RESET_NPC = 32'h0000_0004
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] pc,
    output logic [31:0] npc,
    output logic        if_valid,
    output logic        redirect_pending,
    output logic [7:0]  stall_count
);

    typedef enum logic [1:0] {
        INIT        = 2'd0,
        RUN         = 2'd1,
        STALL       = 2'd2,
        STALL_REDIR = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc_nxt;
    logic [31:0] npc_nxt;
    logic [31:0] redir_target;
    logic [31:0] redir_target_nxt;
    logic        redirect;
    logic [31:0] sel_target;

    // Jump outranks branch when both resolve in the same cycle.
    assign redirect   = jump | branch_taken;
    assign sel_target = jump ? jump_target : branch_target;

    always_comb begin
        state_nxt        = state;
        pc_nxt           = pc;
        npc_nxt          = npc;
        redir_target_nxt = redir_target;
        case (state)
            INIT: begin
                state_nxt = RUN;
            end
            RUN, STALL: begin
                if (stall) begin
                    if (redirect) begin
                        redir_target_nxt = sel_target;
                        state_nxt        = STALL_REDIR;
                    end else begin
                        state_nxt = STALL;
                    end
                end else begin
                    // The delay slot at npc is always fetched before a redirect lands.
                    pc_nxt    = npc;
                    npc_nxt   = redirect ? sel_target : npc + 32'd4;
                    state_nxt = RUN;
                end
            end
            STALL_REDIR: begin
                if (stall) begin
                    if (redirect) begin
                        redir_target_nxt = sel_target;
                    end
                end else begin
                    pc_nxt           = npc;
                    npc_nxt          = redirect ? sel_target : redir_target;
                    redir_target_nxt = 32'h0;
                    state_nxt        = RUN;
                end
            end
            default: begin
                state_nxt = INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= INIT;
            pc           <= RESET_PC;
            npc          <= RESET_NPC;
            redir_target <= 32'h0;
        end else begin
            state        <= state_nxt;
            pc           <= pc_nxt;
            npc          <= npc_nxt;
            redir_target <= redir_target_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_count <= 8'h00;
        end else if (stall && (state != INIT) && (stall_count != 8'hFF)) begin
            stall_count <= stall_count + 8'd1;
        end
    end

    assign redirect_pending = (state == STALL_REDIR);
    assign if_valid         = (state == RUN) && !stall;

endmodule

// File: tb/tb_pc_npc_fetch_unit.sv
// tb/tb_pc_npc_fetch_unit.sv - directed bench for pc_npc_fetch_unit
module tb_pc_npc_fetch_unit;

    logic        clk;
    logic        reset_n;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        if_valid;
    logic        redirect_pending;
    logic [7:0]  stall_count;

    int errors = 0;
    int checks = 0;
    logic [65:0] obs;
    logic [65:0] exp_v;

    pc_npc_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .RESET_NPC(32'h0000_0004)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .stall           (stall),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .jump            (jump),
        .jump_target     (jump_target),
        .pc              (pc),
        .npc             (npc),
        .if_valid        (if_valid),
        .redirect_pending(redirect_pending),
        .stall_count     (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall         = 1'b0;
        jump          = 1'b0;
        branch_taken  = 1'b0;
        jump_target   = 32'h0;
        branch_target = 32'h0;
    endtask

    // Leaves the DUT in INIT just after reset release, between edges.
    task automatic do_reset();
        reset_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        reset_n       = 1'b0;
        stall         = 1'b1;
        jump          = 1'b1;
        jump_target   = 32'h0000_0123;
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0456;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({pc, npc, if_valid, redirect_pending} !== {32'h0, 32'h4, 1'b0, 1'b0} || stall_count !== 8'h00) begin
            errors++;
            $display("FAIL reset_hold actual pc=%h npc=%h ifv=%b rp=%b sc=%h required pc=0 npc=4 ifv=0 rp=0 sc=0",
                     pc, npc, if_valid, redirect_pending, stall_count);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc [4];
        logic [31:0] exp_npc[4];
        logic        exp_ifv[4];
        exp_pc  = '{32'h0, 32'h0, 32'h4, 32'h8};
        exp_npc = '{32'h4, 32'h4, 32'h8, 32'hC};
        exp_ifv = '{1'b0, 1'b1, 1'b1, 1'b1};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            checks++;
            if ({pc, npc, if_valid} !== {exp_pc[i], exp_npc[i], exp_ifv[i]}) begin
                errors++;
                $display("FAIL seq_%0d actual pc=%h npc=%h ifv=%b required pc=%h npc=%h ifv=%b",
                         i, pc, npc, if_valid, exp_pc[i], exp_npc[i], exp_ifv[i]);
            end
        end
    endtask

    // Continues from pc=8/npc=C left by test_sequential.
    task automatic test_branch();
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0100;
        step();
        branch_taken = 1'b0;
        checks++;
        if ({pc, npc} !== {32'hC, 32'h100}) begin
            errors++;
            $display("FAIL branch_slot actual pc=%h npc=%h required pc=c npc=100", pc, npc);
        end
        step();
        checks++;
        if ({pc, npc} !== {32'h100, 32'h104}) begin
            errors++;
            $display("FAIL branch_land actual pc=%h npc=%h required pc=100 npc=104", pc, npc);
        end
    endtask

    task automatic test_stall_jump();
        do_reset();
        repeat (5) step();
        stall = 1'b1;
        #1;
        checks++;
        if ({pc, npc, if_valid} !== {32'h10, 32'h14, 1'b0}) begin
            errors++;
            $display("FAIL stall_start actual pc=%h npc=%h ifv=%b required pc=10 npc=14 ifv=0", pc, npc, if_valid);
        end
        step();
        jump        = 1'b1;
        jump_target = 32'h0000_0200;
        step();
        jump = 1'b0;
        checks++;
        if ({pc, npc, redirect_pending} !== {32'h10, 32'h14, 1'b1}) begin
            errors++;
            $display("FAIL stall_redir actual pc=%h npc=%h rp=%b required pc=10 npc=14 rp=1", pc, npc, redirect_pending);
        end
        step();
        stall = 1'b0;
        step();
        checks++;
        if ({pc, npc, redirect_pending} !== {32'h14, 32'h200, 1'b0} || stall_count !== 8'd3) begin
            errors++;
            $display("FAIL stall_release actual pc=%h npc=%h rp=%b sc=%0d required pc=14 npc=200 rp=0 sc=3",
                     pc, npc, redirect_pending, stall_count);
        end
        step();
        checks++;
        if ({pc, npc, if_valid} !== {32'h200, 32'h204, 1'b1}) begin
            errors++;
            $display("FAIL stall_land actual pc=%h npc=%h ifv=%b required pc=200 npc=204 ifv=1", pc, npc, if_valid);
        end
    endtask

    task automatic test_last_wins();
        do_reset();
        repeat (2) step();
        // pc=4 npc=8: plain stall first, then two redirects while stalled.
        stall = 1'b1;
        step();
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0500;
        step();
        branch_taken = 1'b0;
        jump         = 1'b1;
        jump_target  = 32'h0000_0600;
        step();
        jump  = 1'b0;
        stall = 1'b0;
        step();
        checks++;
        if ({pc, npc} !== {32'h8, 32'h600}) begin
            errors++;
            $display("FAIL last_wins actual pc=%h npc=%h required pc=8 npc=600", pc, npc);
        end
        stall = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0700;
        step();
        branch_taken = 1'b0;
        stall        = 1'b0;
        jump         = 1'b1;
        jump_target  = 32'h0000_0800;
        step();
        jump = 1'b0;
        checks++;
        if ({pc, npc, redirect_pending} !== {32'h600, 32'h800, 1'b0}) begin
            errors++;
            $display("FAIL release_new_target actual pc=%h npc=%h rp=%b required pc=600 npc=800 rp=0",
                     pc, npc, redirect_pending);
        end
    endtask

    task automatic test_both();
        do_reset();
        step();
        jump          = 1'b1;
        jump_target   = 32'h0000_0300;
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0400;
        step();
        clear_inputs();
        checks++;
        if ({pc, npc} !== {32'h4, 32'h300}) begin
            errors++;
            $display("FAIL jump_over_branch actual pc=%h npc=%h required pc=4 npc=300", pc, npc);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        step();
        jump        = 1'b1;
        jump_target = 32'hFFFF_FFFC;
        step();
        jump = 1'b0;
        step();
        checks++;
        if ({pc, npc} !== {32'hFFFF_FFFC, 32'h0}) begin
            errors++;
            $display("FAIL wrap_npc actual pc=%h npc=%h required pc=fffffffc npc=0", pc, npc);
        end
        step();
        checks++;
        if ({pc, npc} !== {32'h0, 32'h4}) begin
            errors++;
            $display("FAIL wrap_pc actual pc=%h npc=%h required pc=0 npc=4", pc, npc);
        end
    endtask

    task automatic test_reset_mid_redir();
        do_reset();
        repeat (3) step();
        stall       = 1'b1;
        jump        = 1'b1;
        jump_target = 32'h0000_0700;
        step();
        jump = 1'b0;
        checks++;
        if ({pc, npc, redirect_pending} !== {32'h8, 32'hC, 1'b1}) begin
            errors++;
            $display("FAIL pre_async_redir actual pc=%h npc=%h rp=%b required pc=8 npc=c rp=1", pc, npc, redirect_pending);
        end
        #2;
        reset_n = 1'b0;
        #1;
        obs   = {pc, npc, if_valid, redirect_pending};
        exp_v = {32'h0, 32'h4, 1'b0, 1'b0};
        checks++;
        if (obs !== exp_v || stall_count !== 8'h00) begin
            errors++;
            $display("FAIL async_reset actual %h sc=%h required %h sc=00", obs, stall_count, exp_v);
        end
        clear_inputs();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step();
        step();
        checks++;
        if ({pc, npc, redirect_pending} !== {32'h4, 32'h8, 1'b0}) begin
            errors++;
            $display("FAIL redirect_discarded actual pc=%h npc=%h rp=%b required pc=4 npc=8 rp=0", pc, npc, redirect_pending);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        stall = 1'b1;
        step();
        checks++;
        if (stall_count !== 8'h00) begin
            errors++;
            $display("FAIL sc_init_ignored actual %h required 00", stall_count);
        end
        repeat (254) step();
        checks++;
        if (stall_count !== 8'hFE) begin
            errors++;
            $display("FAIL sc_254 actual %h required fe", stall_count);
        end
        step();
        checks++;
        if (stall_count !== 8'hFF) begin
            errors++;
            $display("FAIL sc_255 actual %h required ff", stall_count);
        end
        repeat (5) step();
        checks++;
        if (stall_count !== 8'hFF || {pc, npc} !== {32'h0, 32'h4}) begin
            errors++;
            $display("FAIL sc_saturated actual sc=%h pc=%h npc=%h required sc=ff pc=0 npc=4", stall_count, pc, npc);
        end
        stall = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        clear_inputs();
        test_reset();
        test_sequential();
        test_branch();
        test_stall_jump();
        test_last_wins();
        test_both();
        test_wrap();
        test_reset_mid_redir();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
